// File: rtl/iod_ref_clk_training_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// iod_ref_clk_training_ctrl
//
// Fabric-side controller for the DDR3 reference-clock training IOD lane.
// The looped-back CK0 is deserialised into 8-bit words (8'h55 / 8'hAA are the
// two clean phases). The controller reloads the RX delay line to tap 0, then
// sweeps it upward one tap at a time. At each tap it waits for the line to
// settle and then classifies the sampled words. The first stable class becomes
// the reference. The first later tap whose stable class differs is the CK edge.
// The delay is then parked EDGE_OFFSET taps past that edge.
//
// Optional feature (macro IOD_REF_CLK_TRN_EYE_MON_EN):
//   defined   - EYE_MONITOR_CLEAR_FLAGS pulses on every entry into SETTLE, and
//               EYE_MONITOR_EARLY/LATE invalidate the word sampled that cycle.
//   undefined - EYE_MONITOR_CLEAR_FLAGS is constant 0; EARLY/LATE are ignored.
//
// Ports
//   FAB_CLK                  in   fabric clock (same as IOD RX_CLK)
//   RESET                    in   asynchronous active-high reset
//   START                    in   1-cycle pulse, accepted from IDLE/DONE/FAIL
//   RX_DATA[7:0]             in   deserialised CK sample word
//   DELAY_LINE_OUT_OF_RANGE  in   delay-line saturation flag
//   EYE_MONITOR_EARLY/LATE   in   eye-monitor flags
//   DELAY_LINE_LOAD          out  1-cycle pulse, reload delay to tap 0
//   DELAY_LINE_MOVE          out  1-cycle pulse, step delay by one tap
//   DELAY_LINE_DIRECTION     out  1 (increment) whenever not IDLE
//   EYE_MONITOR_CLEAR_FLAGS  out  1-cycle pulse clearing eye-monitor flags
//   TRAIN_BUSY               out  training in progress
//   TRAIN_DONE / TRAIN_ERR   out  level status, cleared by the next START
//   EDGE_TAP[TAP_W-1:0]      out  tap where the class first changed
// -----------------------------------------------------------------------------
module iod_ref_clk_training_ctrl #(
    parameter int TAP_W         = 8,
    parameter int MAX_TAPS      = 255,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CNT    = 4,
    parameter int EDGE_OFFSET   = 16
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [7:0]       RX_DATA,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    output logic             TRAIN_BUSY,
    output logic             TRAIN_DONE,
    output logic             TRAIN_ERR,
    output logic [TAP_W-1:0] EDGE_TAP
);

`ifdef IOD_REF_CLK_TRN_EYE_MON_EN
    localparam logic EYE_EN = 1'b1;
`else
    localparam logic EYE_EN = 1'b0;
`endif

    localparam int SC_W = $clog2(SETTLE_CYCLES + 2);
    localparam int WC_W = $clog2(4 * SAMPLE_CNT + 2);
    localparam int OC_W = $clog2(EDGE_OFFSET + 2);

    localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(MAX_TAPS);
    localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_ONE      = SC_W'(1);
    localparam logic [WC_W-1:0]  RUN_STABLE  = WC_W'(SAMPLE_CNT);
    localparam logic [WC_W-1:0]  WORDS_MAX   = WC_W'(4 * SAMPLE_CNT);
    localparam logic [WC_W-1:0]  WC_ONE      = WC_W'(1);
    localparam logic [OC_W-1:0]  OFF_TOTAL   = OC_W'(EDGE_OFFSET);
    localparam logic [OC_W-1:0]  OC_ONE      = OC_W'(1);

    typedef enum logic [1:0] {
        CLS_INV = 2'd0,
        CLS_C0  = 2'd1,
        CLS_C1  = 2'd2
    } cls_e;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_SETTLE = 4'd2,
        ST_SAMPLE = 4'd3,
        ST_EVAL   = 4'd4,
        ST_STEP   = 4'd5,
        ST_OFFSET = 4'd6,
        ST_DONE   = 4'd7,
        ST_FAIL   = 4'd8
    } state_e;

    // Map a sample word onto its clock phase; eye-monitor hits force INVALID.
    function automatic cls_e classify(input logic [7:0] word, input logic eye_bad);
        cls_e c;
        c = CLS_INV;
        if (eye_bad) begin
            c = CLS_INV;
        end else begin
            case (word)
                8'h55:   c = CLS_C0;
                8'hAA:   c = CLS_C1;
                default: c = CLS_INV;
            endcase
        end
        return c;
    endfunction

    state_e           state_r;
    logic [TAP_W-1:0] tap_r;
    cls_e             ref_cls_r;
    cls_e             prev_cls_r;
    cls_e             stable_cls_r;
    logic [WC_W-1:0]  run_r;
    logic [WC_W-1:0]  words_r;
    logic [SC_W-1:0]  settle_r;
    logic             off_wait_r;
    logic [OC_W-1:0]  off_moves_r;

    logic             eye_bad_s;
    cls_e             word_cls_s;
    logic [WC_W-1:0]  run_next_s;
    logic [WC_W-1:0]  words_next_s;

    // Classify the current word and compute the next run/word counts.
    always_comb begin
        eye_bad_s    = EYE_EN & (EYE_MONITOR_EARLY | EYE_MONITOR_LATE);
        word_cls_s   = classify(RX_DATA, eye_bad_s);
        words_next_s = words_r + WC_ONE;
        run_next_s   = {WC_W{1'b0}};
        if (word_cls_s == CLS_INV) begin
            run_next_s = {WC_W{1'b0}};
        end else if (word_cls_s == prev_cls_r) begin
            run_next_s = run_r + WC_ONE;
        end else begin
            run_next_s = WC_ONE;
        end
    end

    // Training FSM with registered pulse and status outputs.
    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_r                 <= ST_IDLE;
            tap_r                   <= {TAP_W{1'b0}};
            ref_cls_r               <= CLS_INV;
            prev_cls_r              <= CLS_INV;
            stable_cls_r            <= CLS_INV;
            run_r                   <= {WC_W{1'b0}};
            words_r                 <= {WC_W{1'b0}};
            settle_r                <= {SC_W{1'b0}};
            off_wait_r              <= 1'b0;
            off_moves_r             <= {OC_W{1'b0}};
            DELAY_LINE_LOAD         <= 1'b0;
            DELAY_LINE_MOVE         <= 1'b0;
            DELAY_LINE_DIRECTION    <= 1'b0;
            EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
            TRAIN_BUSY              <= 1'b0;
            TRAIN_DONE              <= 1'b0;
            TRAIN_ERR               <= 1'b0;
            EDGE_TAP                <= {TAP_W{1'b0}};
        end else begin
            DELAY_LINE_LOAD         <= 1'b0;
            DELAY_LINE_MOVE         <= 1'b0;
            EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (START) begin
                        state_r              <= ST_LOAD;
                        DELAY_LINE_LOAD      <= 1'b1;
                        DELAY_LINE_DIRECTION <= 1'b1;
                        TRAIN_BUSY           <= 1'b1;
                        TRAIN_DONE           <= 1'b0;
                        TRAIN_ERR            <= 1'b0;
                        EDGE_TAP             <= {TAP_W{1'b0}};
                        tap_r                <= {TAP_W{1'b0}};
                        ref_cls_r            <= CLS_INV;
                    end
                end
                ST_LOAD, ST_STEP: begin
                    // STEP is the only place the sweep can run out of range.
                    if ((state_r == ST_STEP) &&
                        ((tap_r == TAP_MAX) || DELAY_LINE_OUT_OF_RANGE)) begin
                        state_r    <= ST_FAIL;
                        TRAIN_ERR  <= 1'b1;
                        TRAIN_BUSY <= 1'b0;
                    end else begin
                        if (state_r == ST_STEP) begin
                            DELAY_LINE_MOVE <= 1'b1;
                            tap_r           <= tap_r + TAP_ONE;
                        end
                        state_r                 <= ST_SETTLE;
                        settle_r                <= {SC_W{1'b0}};
                        run_r                   <= {WC_W{1'b0}};
                        words_r                 <= {WC_W{1'b0}};
                        prev_cls_r              <= CLS_INV;
                        EYE_MONITOR_CLEAR_FLAGS <= EYE_EN;
                    end
                end
                ST_SETTLE: begin
                    if (settle_r == SETTLE_LAST) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        settle_r <= settle_r + SC_ONE;
                    end
                end
                ST_SAMPLE: begin
                    prev_cls_r <= word_cls_s;
                    run_r      <= run_next_s;
                    words_r    <= words_next_s;
                    if (run_next_s == RUN_STABLE) begin
                        stable_cls_r <= word_cls_s;
                        state_r      <= ST_EVAL;
                    end else if (words_next_s == WORDS_MAX) begin
                        state_r <= ST_STEP;
                    end
                end
                ST_EVAL: begin
                    if (ref_cls_r == CLS_INV) begin
                        ref_cls_r <= stable_cls_r;
                        state_r   <= ST_STEP;
                    end else if (stable_cls_r != ref_cls_r) begin
                        EDGE_TAP <= tap_r;
                        if (EDGE_OFFSET == 0) begin
                            state_r    <= ST_DONE;
                            TRAIN_DONE <= 1'b1;
                            TRAIN_BUSY <= 1'b0;
                        end else begin
                            state_r     <= ST_OFFSET;
                            off_wait_r  <= 1'b0;
                            off_moves_r <= {OC_W{1'b0}};
                        end
                    end else begin
                        state_r <= ST_STEP;
                    end
                end
                ST_OFFSET: begin
                    // Alternates a move slot with a SETTLE_CYCLES-long wait.
                    if (!off_wait_r) begin
                        if ((tap_r == TAP_MAX) || DELAY_LINE_OUT_OF_RANGE) begin
                            state_r    <= ST_FAIL;
                            TRAIN_ERR  <= 1'b1;
                            TRAIN_BUSY <= 1'b0;
                        end else begin
                            DELAY_LINE_MOVE <= 1'b1;
                            tap_r           <= tap_r + TAP_ONE;
                            off_moves_r     <= off_moves_r + OC_ONE;
                            off_wait_r      <= 1'b1;
                            settle_r        <= {SC_W{1'b0}};
                        end
                    end else if (settle_r == SETTLE_LAST) begin
                        if (off_moves_r == OFF_TOTAL) begin
                            state_r    <= ST_DONE;
                            TRAIN_DONE <= 1'b1;
                            TRAIN_BUSY <= 1'b0;
                        end else begin
                            off_wait_r <= 1'b0;
                        end
                    end else begin
                        settle_r <= settle_r + SC_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iod_ref_clk_training_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_iod_ref_clk_training_ctrl
//
// Scoreboard bench. Each test pushes its expected events into a queue:
// reset snapshot, LOAD pulse, end of training. Monitor processes pop and
// compare when the DUT shows the matching event. A small IOD model tracks the
// tap from LOAD/MOVE pulses and drives RX_DATA and the flags for that tap.
// A second instance with MAX_TAPS=31 covers sweep exhaustion.
// -----------------------------------------------------------------------------
module tb_iod_ref_clk_training_ctrl;

    localparam int SETTLE = 8;
    localparam int K_RST  = 0;
    localparam int K_LOAD = 1;
    localparam int K_END  = 2;
`ifdef IOD_REF_CLK_TRN_EYE_MON_EN
    localparam bit EYE = 1'b1;
`else
    localparam bit EYE = 1'b0;
`endif

    typedef struct {
        int         kind;
        int         moves;
        int         clears;
        logic       done;
        logic       err;
        logic [7:0] edge_tap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start31 = 1'b0;
    logic [7:0] rx = 8'h00;
    logic       oor = 1'b0;
    logic       early = 1'b0;
    logic       late = 1'b0;

    logic       d_load, d_move, d_dir, d_clr, busy, done, err;
    logic [7:0] edge_tap;
    logic       d_load31, d_move31, d_dir31, d_clr31, busy31, done31, err31;
    logic [7:0] edge_tap31;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   mode = 0;
    int   tap_m = 0;
    exp_t q[$];
    exp_t q31[$];

    iod_ref_clk_training_ctrl dut (
        .FAB_CLK(clk), .RESET(rst), .START(start), .RX_DATA(rx),
        .DELAY_LINE_OUT_OF_RANGE(oor), .EYE_MONITOR_EARLY(early),
        .EYE_MONITOR_LATE(late), .DELAY_LINE_LOAD(d_load),
        .DELAY_LINE_MOVE(d_move), .DELAY_LINE_DIRECTION(d_dir),
        .EYE_MONITOR_CLEAR_FLAGS(d_clr), .TRAIN_BUSY(busy),
        .TRAIN_DONE(done), .TRAIN_ERR(err), .EDGE_TAP(edge_tap)
    );

    iod_ref_clk_training_ctrl #(.MAX_TAPS(31)) dut31 (
        .FAB_CLK(clk), .RESET(rst), .START(start31), .RX_DATA(8'h55),
        .DELAY_LINE_OUT_OF_RANGE(1'b0), .EYE_MONITOR_EARLY(1'b0),
        .EYE_MONITOR_LATE(1'b0), .DELAY_LINE_LOAD(d_load31),
        .DELAY_LINE_MOVE(d_move31), .DELAY_LINE_DIRECTION(d_dir31),
        .EYE_MONITOR_CLEAR_FLAGS(d_clr31), .TRAIN_BUSY(busy31),
        .TRAIN_DONE(done31), .TRAIN_ERR(err31), .EDGE_TAP(edge_tap31)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int kind, input int moves, input int clears,
                                input logic dn, input logic er, input int et);
        exp_t e;
        e.kind = kind; e.moves = moves; e.clears = clears;
        e.done = dn; e.err = er; e.edge_tap = 8'(et);
        return e;
    endfunction

    // IOD loopback model: sample word and flags as a function of the tap.
    function automatic logic [7:0] pattern(input int m, input int t);
        logic [7:0] w;
        case (m)
            1:       w = (t < 20) ? 8'h55 : 8'hAA;
            2:       w = (t < 3) ? 8'h37 : ((t < 10) ? 8'hAA : 8'h55);
            6:       w = (t < 8) ? 8'h55 : 8'hAA;
            default: w = 8'h55;
        endcase
        return w;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst || d_load) tap_m = 0;
            else if (d_move) tap_m = tap_m + 1;
            rx    = pattern(mode, tap_m);
            oor   = (mode == 4) && (tap_m >= 5);
            early = (mode == 6) && (tap_m == 0);
        end
    end

    // Monitor for the main instance.
    initial begin
        int moves = 0, clears = 0, gap_viol = 0, ovl = 0, dir_viol = 0;
        int last_move = -1000;
        logic prev_rst = 1'b0, prev_fin = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!prev_rst) begin
                    if (q.size() == 0) check("unexpected_reset", 1, 0);
                    else begin
                        e = q.pop_front();
                        check("rst_kind", e.kind, K_RST);
                        check("rst_outputs", {d_load, d_move, d_dir, d_clr, busy, done, err, edge_tap}, 0);
                    end
                end
                prev_fin = 1'b0;
            end else begin
                if (d_load) begin
                    if (q.size() == 0) check("unexpected_load", 1, 0);
                    else begin
                        e = q.pop_front();
                        check("load_kind", e.kind, K_LOAD);
                        check("load_latency", cyc - start_cyc, 1);
                        check("load_status_clear", {done, err, edge_tap}, 0);
                        check("load_busy_dir", {busy, d_dir}, 3);
                    end
                    moves = 0; clears = 0; gap_viol = 0; ovl = 0; dir_viol = 0;
                    last_move = -1000;
                end
                if (d_load && d_move) ovl++;
                if (d_move) begin
                    if (cyc - last_move < SETTLE + 1) gap_viol++;
                    last_move = cyc;
                    moves++;
                end
                if (d_clr) clears++;
                if (busy && !d_dir) dir_viol++;
                if ((done || err) && !prev_fin) begin
                    if (q.size() == 0) check("unexpected_end", 1, 0);
                    else begin
                        e = q.pop_front();
                        check("end_kind", e.kind, K_END);
                        check("train_done", done, e.done);
                        check("train_err", err, e.err);
                        check("edge_tap", edge_tap, e.edge_tap);
                        check("move_count", moves, e.moves);
                        check("clear_count", clears, e.clears);
                        check("busy_at_end", busy, 0);
                        check("protocol_violations", gap_viol + ovl + dir_viol, 0);
                    end
                end
                prev_fin = done || err;
            end
            prev_rst = rst;
        end
    end

    // Monitor for the MAX_TAPS=31 instance.
    initial begin
        int moves = 0;
        logic prev_fin = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (d_load31) moves = 0;
            if (d_move31) moves++;
            if (!rst && (done31 || err31) && !prev_fin) begin
                if (q31.size() == 0) check("unexpected_end31", 1, 0);
                else begin
                    e = q31.pop_front();
                    check("err31", err31, e.err);
                    check("done31", done31, e.done);
                    check("move_count31", moves, e.moves);
                end
            end
            prev_fin = !rst && (done31 || err31);
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done || err) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        q.push_back(mk(K_RST, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Edge at tap 20 then 16 offset moves; a second START mid-sweep is ignored.
        mode = 1;
        q.push_back(mk(K_LOAD, 0, 0, 0, 0, 0));
        q.push_back(mk(K_END, 36, EYE ? 21 : 0, 1, 0, 20));
        do_start();
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("t1_timeout");

        // Invalid words at taps 0..2, reference C1 at tap 3, edge at 10.
        mode = 2;
        q.push_back(mk(K_LOAD, 0, 0, 0, 0, 0));
        q.push_back(mk(K_END, 26, EYE ? 11 : 0, 1, 0, 10));
        do_start();
        wait_end("t2_timeout");

        // Out of range at tap 5: fail in its STEP after exactly 5 moves.
        mode = 4;
        q.push_back(mk(K_LOAD, 0, 0, 0, 0, 0));
        q.push_back(mk(K_END, 5, EYE ? 6 : 0, 0, 1, 0));
        do_start();
        wait_end("t4_timeout");

        // Constant pattern with MAX_TAPS=31: 31 moves then error.
        q31.push_back(mk(K_END, 31, 0, 0, 1, 0));
        @(negedge clk);
        start31 = 1'b1;
        @(negedge clk);
        start31 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done31 || err31) begin
                seen = 1'b1;
                break;
            end
        end
        check("t3_timeout", seen, 1);
        repeat (3) @(negedge clk);

`ifdef IOD_REF_CLK_TRN_EYE_MON_EN
        // EARLY at tap 0 makes it unstable; reference at tap 1, edge at 8.
        mode = 6;
        q.push_back(mk(K_LOAD, 0, 0, 0, 0, 0));
        q.push_back(mk(K_END, 24, 9, 1, 0, 8));
        do_start();
        wait_end("t6_timeout");
`endif

        // Reset during OFFSET aborts; a fresh START then completes normally.
        mode = 1;
        q.push_back(mk(K_LOAD, 0, 0, 0, 0, 0));
        do_start();
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (tap_m >= 22) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_reach_offset", seen, 1);
        q.push_back(mk(K_RST, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.push_back(mk(K_LOAD, 0, 0, 0, 0, 0));
        q.push_back(mk(K_END, 36, EYE ? 21 : 0, 1, 0, 20));
        do_start();
        wait_end("t5_timeout");

        check("queue_drained", q.size() + q31.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
